uart_tx_serializer: RTL and testbench

//   Clocked UART transmitter: accepts bytes over a valid/ready interface, buffers them in a small FIFO,
//   and serializes them as 8N1 frames (optionally 8E1/8O1) on tx_o.

---
 rtl/uart_tx_serializer.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmitter. Bytes arrive over a valid/ready handshake, are queued
//   in a small FIFO and are sent as 8N1 frames on tx_o. When the macro
//   UART_TX_PARITY_EN is defined, a parity bit is inserted between the data
//   bits and the stop bit, giving 8E1 or 8O1 frames.
//
// Parameters
//   CLK_FREQ_HZ  input clock frequency
//   BAUD_RATE    line rate; DIV = CLK_FREQ_HZ/BAUD_RATE clocks per bit (>= 2)
//   FIFO_DEPTH   byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk           clock
//   rst_n         asynchronous reset, active low
//   tx_data_i     byte to send
//   tx_valid_i    tx_data_i valid
//   tx_ready_o    FIFO can accept a byte (not full)
//   parity_odd_i  1: odd parity, 0: even parity (used only with UART_TX_PARITY_EN)
//   tx_o          serial line, idle high, registered
//   busy_o        a frame is being sent
//   tx_done_o     one-cycle pulse in the last cycle of each stop bit
//   fifo_level_o  number of bytes buffered
module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD_RATE   = 781250,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      tx_data_i,
  input  logic                            tx_valid_i,
  output logic                            tx_ready_o,
  input  logic                            parity_odd_i,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic                            tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO   = {LVL_W{1'b0}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  // Parity of one byte; odd selects odd parity (bit makes total count odd).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction
`else
  // parity_odd_i has no function in this build.
  logic unused_parity_s;
  assign unused_parity_s = parity_odd_i;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [7:0]       head_s;

  assign full_s     = (level_r == LVL_FULL);
  assign empty_s    = (level_r == LVL_ZERO);
  assign push_s     = tx_valid_i & ~full_s;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign tx_ready_o = ~full_s;

  // FIFO storage, pointers and fill level; a push and pop together leave the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= tx_data_i;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  logic [2:0]       state_r,   state_n;
  logic [CNT_W-1:0] cnt_r,     cnt_n;
  logic [2:0]       bit_idx_r, bit_idx_n;
  logic [7:0]       shift_r,   shift_n;
  logic             par_r,     par_n;
  logic             done_n;
  logic             tx_n;
  logic             tx_r;
  logic             busy_r;
  logic             done_r;

  // Next-state logic. A pop loads the shift register and latches the parity
  // bit, so later changes on parity_odd_i cannot disturb a frame in flight.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    par_n     = par_r;
    done_n    = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_n = S_START;
          cnt_n   = CNT_RELOAD;
          shift_n = head_s;
`ifdef UART_TX_PARITY_EN
          par_n   = parity_bit(head_s, parity_odd_i);
`else
          par_n   = 1'b0;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == CNT_ZERO) begin
          state_n   = S_DATA;
          cnt_n     = CNT_RELOAD;
          bit_idx_n = 3'd0;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_n = CNT_RELOAD;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx_r + 3'd1;
            shift_n   = {1'b0, shift_r[7:1]};
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = S_STOP;
          cnt_n   = CNT_RELOAD;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt_r == CNT_ZERO) begin
          // Back-to-back: the next start bit follows the stop bit directly.
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_n = S_START;
            cnt_n   = CNT_RELOAD;
            shift_n = head_s;
`ifdef UART_TX_PARITY_EN
            par_n   = parity_bit(head_s, parity_odd_i);
`else
            par_n   = 1'b0;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_r - CNT_ONE;
          // Registered pulse lands on the final stop-bit cycle (counter at 0).
          done_n = (cnt_r == CNT_ONE);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  // Line value for the upcoming state, so tx_o can be driven from a flop.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  // FSM state and registered outputs; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      tx_r      <= tx_n;
      busy_r    <= (state_n != S_IDLE);
      done_r    <= done_n;
    end
  end

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign tx_done_o    = done_r;
  assign fifo_level_o = level_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int DIV = 32;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       tx_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       tx_done_o;
  logic [2:0] fifo_level_o;

  uart_tx_serializer #(
    .CLK_FREQ_HZ(25000000),
    .BAUD_RATE  (781250),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .parity_odd_i(parity_odd_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .tx_done_o   (tx_done_o),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: decodes the line by sampling each bit mid-way and scores every frame.
  int          mon_cnt = 0;
  logic        mon_active = 1'b0;
  logic [10:0] mon_bits = '0;
  logic        mon_early_done = 1'b0;
  int          busy_cycles = 0;
  int          tx_edges = 0;
  logic        tx_prev = 1'b1;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (busy_o === 1'b1) busy_cycles++;
    if (tx_o !== tx_prev) tx_edges++;
    tx_prev = tx_o;
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx_o === 1'b0) begin
        mon_active     = 1'b1;
        mon_cnt        = 0;
        mon_bits       = '0;
        mon_early_done = tx_done_o;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % DIV) == (DIV / 2)) mon_bits[mon_cnt / DIV] = tx_o;
      if (mon_cnt == FRAME - 1) begin
        mon_active = 1'b0;
        check("frame_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rx_data", {24'd0, mon_bits[8:1]}, {24'd0, mon_e.data});
          check("rx_start_stop", {30'd0, mon_bits[0], mon_bits[FB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", {31'd0, mon_bits[9]}, {31'd0, mon_e.par});
`endif
          check("done_pulse", {30'd0, mon_early_done, tx_done_o}, 32'd1);
        end
      end else if (tx_done_o === 1'b1) begin
        mon_early_done = 1'b1;
      end
    end
  end

  // Offer one byte; returns at the handshake edge + 1ns with the cycle stamp.
  task automatic push_byte(input logic [7:0] b, input logic p_odd, input logic exp_par,
                           output int unsigned hs);
    int waited = 0;
    tx_data_i    = b;
    parity_odd_i = p_odd;
    tx_valid_i   = 1'b1;
    @(negedge clk);
    while (tx_ready_o !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", {31'd0, tx_ready_o}, 32'd1);
    @(posedge clk);
    exp_q.push_back({b, exp_par});
    #1;
    hs         = cyc;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy_o !== 1'b0 || fifo_level_o !== 3'd0 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time",
          (busy_o === 1'b0 && fifo_level_o === 3'd0 && exp_q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  logic [7:0] s3_data [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
  logic       s3_par  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int unsigned h;
    int unsigned h0;
    int          viol;

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    check("reset_outputs", {25'd0, tx_o, tx_ready_o, busy_o, tx_done_o, fifo_level_o}, 32'h60);
    @(negedge clk);
    #2 rst_n = 1'b1;
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({tx_o, tx_ready_o, busy_o, tx_done_o, fifo_level_o} !== 7'b1100000) viol++;
    end
    check("idle_1000_cycles", viol, 32'd0);

    // Single byte 0x65: latency and tx_done timing
    @(posedge clk); #1;
    push_byte(8'h65, 1'b0, 1'b0, h);
    @(negedge clk);
    check("latency_n1_high", {31'd0, tx_o}, 32'd1);
    @(negedge clk);
    check("latency_n2_low", {31'd0, tx_o}, 32'd0);
    repeat (FRAME - 2) @(negedge clk);
    check("done_before_last", {31'd0, tx_done_o}, 32'd0);
    @(negedge clk);
    check("done_last_cycle", {31'd0, tx_done_o}, 32'd1);
    @(negedge clk);
    check("idle_after_frame", {29'd0, busy_o, tx_o, tx_done_o}, 32'b010);
    wait_idle(100);

    // Six bytes back-to-back, FIFO fills
    @(posedge clk); #1;
    busy_cycles = 0;
    push_byte(s3_data[0], 1'b0, s3_par[0], h0);
    for (int i = 1; i < 5; i++) push_byte(s3_data[i], 1'b0, s3_par[i], h);
    @(negedge clk);
    check("fifo_full", {28'd0, tx_ready_o, fifo_level_o}, {28'd0, 1'b0, 3'd4});
    push_byte(s3_data[5], 1'b0, s3_par[5], h);
    check("sixth_accept_gap", h - h0, FRAME + 2);
    wait_idle(8 * FRAME);
    check("busy_contiguous", busy_cycles, 6 * FRAME);

    // Reset in the middle of data bit 3 of 0xF0, with 0x3C queued
    @(posedge clk); #1;
    push_byte(8'hF0, 1'b0, 1'b0, h);
    push_byte(8'h3C, 1'b0, 1'b0, h);
    repeat (138) @(negedge clk);
    check("bit3_low", {28'd0, tx_o, fifo_level_o}, {28'd0, 1'b0, 3'd1});
    #2 rst_n = 1'b0;
    #1;
    check("reset_midframe", {27'd0, tx_o, fifo_level_o, busy_o}, {27'd0, 1'b1, 3'd0, 1'b0});
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tx_edges = 0;
    repeat (400) @(negedge clk);
    check("no_edges_after_reset", tx_edges, 32'd0);

    // 0x65 with even then odd parity (toggled after pop in the second frame)
    @(posedge clk); #1;
    busy_cycles = 0;
    push_byte(8'h65, 1'b0, 1'b0, h);
    wait_idle(FRAME + 50);
    check("frame_len_even", busy_cycles, FRAME);
    @(posedge clk); #1;
    busy_cycles = 0;
    push_byte(8'h65, 1'b1, 1'b1, h);
    @(posedge clk); #1;
    repeat (40) begin
      parity_odd_i = ~parity_odd_i;
      repeat (7) @(posedge clk);
      #1;
    end
    wait_idle(FRAME + 50);
    check("frame_len_toggle", busy_cycles, FRAME);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
